// File: rtl/dot_max_engine.sv
// dot_max_engine: sequential unsigned dot product over LANES element pairs,
// tracking the largest result seen and the sample index that produced it.
module dot_max_engine #(
    parameter int LANES = 4,
    parameter int DW = 4,
    parameter int IDX_W = 8,
    localparam int ACC_W = 2 * DW + $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [DW-1:0]    in_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [ACC_W-1:0] best,
    output logic [IDX_W-1:0] best_idx,
    output logic             best_valid,
    input  logic             clear_best
);
    localparam int PW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t           state;
    logic [DW-1:0]    x_reg [LANES];
    logic [DW-1:0]    w_reg [LANES];
    logic [PW-1:0]    ptr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;
    logic [IDX_W-1:0] sample_cnt;
    logic             accept;
    logic             take_best;

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign prod      = ACC_W'(x_reg[ptr]) * ACC_W'(w_reg[ptr]);
    // a clear coinciding with completion lets the new result seed the maximum
    assign take_best = clear_best || !best_valid || acc > best;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                x_reg[k] <= '0;
                w_reg[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (in_sel) w_reg[k] <= w_reg[k+1];
                else x_reg[k] <= x_reg[k+1];
            end
            if (in_sel) w_reg[LANES-1] <= in_data;
            else x_reg[LANES-1] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            acc        <= '0;
            done       <= 1'b0;
            result     <= '0;
            best       <= '0;
            best_idx   <= '0;
            best_valid <= 1'b0;
            sample_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COMPUTE;
                        acc   <= '0;
                        ptr   <= '0;
                    end
                end
                COMPUTE: begin
                    acc <= acc + prod;
                    ptr <= ptr + 1'b1;
                    if (ptr == PW'(LANES - 1)) state <= FINISH;
                end
                FINISH: begin
                    state      <= IDLE;
                    result     <= acc;
                    done       <= 1'b1;
                    sample_cnt <= sample_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (state == FINISH && take_best) begin
                best       <= acc;
                best_idx   <= sample_cnt;
                best_valid <= 1'b1;
            end else if (clear_best) begin
                best       <= '0;
                best_idx   <= '0;
                best_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dot_max_engine.sv
// tb_dot_max_engine: directed stimulus with a behavioural reference model and per-cycle output compare.
module tb_dot_max_engine;
    logic       clk, rst_n, in_valid, in_sel, start, clear_best;
    logic [3:0] in_data;
    logic       in_ready, busy, done, best_valid;
    logic [9:0] result, best;
    logic [7:0] best_idx;

    int n_chk = 0;
    int n_fail = 0;

    dot_max_engine #(.LANES(4), .DW(4), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .start(start), .busy(busy),
        .done(done), .result(result), .best(best), .best_idx(best_idx),
        .best_valid(best_valid), .clear_best(clear_best)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: the dot product is taken whole at start, then delivered LANES+1 cycles later
    int m_x [4];
    int m_w [4];
    int cnt_m = 0, acc_m = 0, res_m = 0, best_m = 0, idx_m = 0, samp_m = 0;
    bit bv_m = 0, done_m = 0, init = 0;

    always @(posedge clk) begin : model
        int nx [4];
        int nw [4];
        int s;
        bit comp;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_x[k] <= 0;
                m_w[k] <= 0;
            end
            cnt_m <= 0; acc_m <= 0; res_m <= 0; best_m <= 0; idx_m <= 0;
            samp_m <= 0; bv_m <= 0; done_m <= 0; init <= 1;
        end else begin
            nx = m_x;
            nw = m_w;
            comp = 0;
            done_m <= 0;
            if (cnt_m == 0) begin
                if (in_valid) begin
                    for (int k = 0; k < 3; k++) begin
                        if (in_sel) nw[k] = nw[k+1];
                        else nx[k] = nx[k+1];
                    end
                    if (in_sel) nw[3] = int'(in_data);
                    else nx[3] = int'(in_data);
                end
                if (start) begin
                    s = 0;
                    for (int k = 0; k < 4; k++) s += nx[k] * nw[k];
                    acc_m <= s;
                    cnt_m <= 5;
                end
            end else begin
                cnt_m <= cnt_m - 1;
                if (cnt_m == 1) begin
                    comp = 1;
                    done_m <= 1;
                    res_m <= acc_m;
                    samp_m <= (samp_m + 1) % 256;
                    if (clear_best || !bv_m || acc_m > best_m) begin
                        best_m <= acc_m;
                        idx_m <= samp_m;
                        bv_m <= 1;
                    end
                end
            end
            if (clear_best && !comp) begin
                best_m <= 0;
                idx_m <= 0;
                bv_m <= 0;
            end
            m_x <= nx;
            m_w <= nw;
        end
    end

    always @(negedge clk) begin
        if (init) begin
            chk("in_ready", int'(in_ready), int'(cnt_m == 0));
            chk("busy", int'(busy), int'(cnt_m != 0));
            chk("done", int'(done), int'(done_m));
            chk("result", int'(result), res_m);
            chk("best", int'(best), best_m);
            chk("best_idx", int'(best_idx), idx_m);
            chk("best_valid", int'(best_valid), int'(bv_m));
        end
    end

    task automatic beat(input logic sel, input int v);
        in_valid = 1;
        in_sel = sel;
        in_data = 4'(v);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic load(input logic sel, input int a, input int b, input int c, input int d);
        beat(sel, a);
        beat(sel, b);
        beat(sel, c);
        beat(sel, d);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("done_seen", int'(done), 1);
    endtask

    task automatic run();
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done();
    endtask

    task automatic clear();
        clear_best = 1;
        @(negedge clk);
        clear_best = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_sel = 0; in_data = 0; start = 0; clear_best = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_best_valid", int'(best_valid), 0);
        chk("rst_result", int'(result), 0);

        load(0, 1, 2, 3, 4);
        load(1, 2, 2, 2, 2);
        run();
        chk("s0_result", int'(result), 20);
        chk("s0_best", int'(best), 20);
        chk("s0_idx", int'(best_idx), 0);
        chk("s0_valid", int'(best_valid), 1);

        load(0, 15, 15, 15, 15);
        load(1, 15, 15, 15, 15);
        run();
        chk("max_result", int'(result), 900);
        chk("max_best", int'(best), 900);

        clear();
        chk("clr_best", int'(best), 0);
        chk("clr_valid", int'(best_valid), 0);
        load(1, 2, 2, 2, 2);
        load(0, 1, 2, 3, 4);
        run();
        load(0, 1, 2, 3, 0);
        run();
        chk("s3_result", int'(result), 12);
        load(0, 1, 2, 3, 4);
        run();
        chk("tie_best", int'(best), 20);
        chk("tie_idx", int'(best_idx), 2);
        load(0, 15, 15, 15, 15);
        run();
        chk("s5_best", int'(best), 120);
        chk("s5_idx", int'(best_idx), 5);

        load(0, 1, 2, 3, 4);
        start = 1;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_sel = 0; in_data = 7;
        @(negedge clk);
        chk("held_ready", int'(in_ready), 0);
        wait_done();
        chk("held_result", int'(result), 20);
        @(negedge clk);
        in_valid = 0;
        run();
        chk("after_held", int'(result), 32);

        clear();
        load(0, 1, 2, 3, 4);
        run();
        chk("s8_best", int'(best), 20);
        load(0, 1, 1, 1, 2);
        load(1, 1, 1, 1, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        clear_best = 1;
        @(negedge clk);
        clear_best = 0;
        chk("cc_done", int'(done), 1);
        chk("cc_best", int'(best), 5);
        chk("cc_valid", int'(best_valid), 1);
        chk("cc_idx", int'(best_idx), 9);

        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_best", int'(best), 0);
        chk("abort_idx", int'(best_idx), 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        chk("abort_ready", int'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_max_engine.md
Name: dot_max_engine

Overview:
- Parametrised successor to the team's 4-lane nibble dot-product/max tracker.
- Holds LANES input and weight elements of DW bits, each loaded through a valid/ready stream.
- On start, computes the unsigned dot product sequentially, one lane per cycle.
- Tracks the running maximum result and the sample index that produced it. Sits between the pin-level loader and the output mux.

Parameters:
LANES, 4, number of input/weight element pairs (>=2)
DW, 4, element width in bits
IDX_W, 8, width of sample counter and best index
ACC_W (localparam), 2*DW+$clog2(LANES), result width; never overflows

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  load beat valid
in_ready  out  1  engine can accept a load beat
in_sel  in  1  1 = beat targets weights, 0 = beat targets inputs
in_data  in  DW  element value
start  in  1  request a dot-product computation
busy  out  1  computation in progress
done  out  1  one-cycle pulse, result valid
result  out  ACC_W  last computed dot product
best  out  ACC_W  largest result since reset/clear
best_idx  out  IDX_W  sample index of best
best_valid  out  1  best holds a real sample
clear_best  in  1  forget running maximum

Behaviour:
- Reset (rst_n=0 at posedge): all element registers=0, state IDLE, in_ready=1 after reset, busy=0, done=0, result=0, best=0, best_idx=0, best_valid=0, sample counter=0.
- States: IDLE, COMPUTE, FINISH.
- IDLE: in_ready=1, busy=0.
  - Beat accepted when in_valid&&in_ready.
  - Selected bank shifts: new element enters lane LANES-1, every lane k takes lane k+1, lane 0 is discarded. After LANES beats, the first beat sits in lane 0.
  - The unselected bank is unchanged.
- start in IDLE -> COMPUTE next cycle, accumulator cleared, lane pointer=0.
  - A beat accepted in the same cycle as start is applied and is included in the computation.
- COMPUTE: in_ready=0, busy=1. Each cycle: acc += input[ptr]*weight[ptr] (unsigned, full ACC_W precision); ptr++.
  - After lane LANES-1 is processed -> FINISH.
  - Element registers are frozen.
- FINISH (1 cycle): busy=1, in_ready=0.
  - On the FINISH->IDLE edge: result<=acc and done pulses high for the following cycle.
  - The sample counter increments and wraps at 2^IDX_W.
- Latency: start sampled at edge t -> done=1 and result valid in the cycle after edge t+LANES+1. result holds until the next completion.
- Max update, at the same edge as the result:
  - If !best_valid or acc > best (strict): best<=acc, best_idx<=current sample counter (pre-increment value), best_valid<=1.
  - Ties do not update.
- clear_best alone: best<=0, best_idx<=0, best_valid<=0. The sample counter is not cleared.
- clear_best on the same edge as a completion: treat best_valid as 0, so the new result is loaded and best_valid=1.
- start while busy: ignored, not queued.
- in_valid while busy: not accepted, since in_ready=0. The source must hold the beat.
- rst_n low mid-computation: abort immediately to reset values; no done pulse.
- in_data and in_sel are don't-care when in_valid=0.

Test Plan (LANES=4, DW=4, IDX_W=8):
- Load inputs 1,2,3,4 and weights 2,2,2,2, then pulse start at edge t -> done at cycle after edge t+5, result=20, best=20, best_idx=0, best_valid=1.
- Load all inputs and weights to 15, start -> result=900 (no overflow in 10 bits); best=900.
- Three samples with results 20, 12, 20 -> best=20, best_idx=0 (tie not taken); sample counter=3.
- Hold in_valid=1 during COMPUTE with value 7 -> in_ready=0, banks unchanged; the beat is accepted on the first IDLE cycle after done.
- Assert clear_best on the completion edge of a sample giving 5 while best=20 -> best=5, best_valid=1, best_idx=that sample's index.
- Assert rst_n=0 two cycles after start -> no done pulse; all outputs 0; in_ready=1 once reset is released.
